// File: rtl/sf_palette_pkg.sv
// Shared types and constants for the double-buffered palette engine.
// Holds the default colour table loaded into every palette after reset.
package sf_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } init_state_e;

    localparam int DEFAULT_DEPTH = 32;

    localparam logic [11:0] DEFAULT_PALETTE [DEFAULT_DEPTH] = '{
        12'hA41, 12'h322, 12'hEB8, 12'h435, 12'h000, 12'hA45, 12'h125, 12'hFFF,
        12'hE12, 12'h420, 12'h865, 12'h634, 12'hE86, 12'h110, 12'h547, 12'h235,
        12'h867, 12'h720, 12'hC43, 12'h121, 12'h110, 12'hA65, 12'hFD9, 12'h410,
        12'hD75, 12'hC77, 12'h754, 12'h999, 12'h820, 12'h643, 12'hFFD, 12'hBBC
    };

    // Wider colour indices alias onto the 32-entry table.
    function automatic rgb_t default_colour(input int unsigned idx);
        logic [4:0] slot;
        slot = idx[4:0];
        return rgb_t'(DEFAULT_PALETTE[slot]);
    endfunction

endpackage

// File: rtl/sf_palette_ram.sv
// Simple dual-port palette storage: one write port, one registered read port.
// Contents are not reset; the engine's init walk fills them.
module sf_palette_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sf_palette_engine.sv
// Double-buffered colour lookup with per-frame fade; palettes written to the
// shadow bank become visible at the first frame_start after a swap request.
module sf_palette_engine
    import sf_palette_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int PAL_W   = 2,
    parameter int CH_W    = 4,
    parameter int FADE_W  = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid,
    input  logic [INDEX_W-1:0] pix_index,
    input  logic [PAL_W-1:0]   pix_pal,
    output logic [CH_W-1:0]    red,
    output logic [CH_W-1:0]    green,
    output logic [CH_W-1:0]    blue,
    output logic               out_valid,
    input  logic               wr_en,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [3*CH_W-1:0]  wr_data,
    output logic               wr_ready,
    input  logic               swap_req,
    input  logic               frame_start,
    input  logic [FADE_W-1:0]  fade_level,
    output logic               init_done
);

    localparam int ADDR_W = 1 + PAL_W + INDEX_W;
    localparam int DATA_W = 3 * CH_W;
    localparam int PROD_W = CH_W + FADE_W + 1;

    function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0]   ch,
                                                input logic [FADE_W-1:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(ch) * (PROD_W'(lvl) + PROD_W'(1));
        return prod[FADE_W +: CH_W];
    endfunction

    init_state_e       state, state_nxt;
    logic [ADDR_W-1:0] init_addr;
    logic              active_bank;
    logic              swap_pending;
    logic              swap_fire;
    logic [FADE_W-1:0] fade_reg;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              vld_p0;
    logic              run_p0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && (&init_addr))
            state_nxt = ST_RUN;
    end

    // During INIT the RAM write port belongs to the default-load walk.
    always_comb begin
        init_done = (state == ST_RUN);
        wr_ready  = (state == ST_RUN);
        ram_we    = 1'b0;
        ram_waddr = {~active_bank, wr_pal, wr_index};
        ram_wdata = wr_data;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_addr;
            ram_wdata = DATA_W'(default_colour(32'(init_addr[INDEX_W-1:0])));
        end else begin
            ram_we    = wr_en;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            init_addr <= '0;
        else if (state == ST_INIT)
            init_addr <= init_addr + ADDR_W'(1);
    end

    assign swap_fire = frame_start & swap_pending & init_done;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
            fade_reg     <= '1;
        end else begin
            if (swap_fire)
                active_bank <= ~active_bank;
            if (swap_req)
                swap_pending <= 1'b1;
            else if (swap_fire)
                swap_pending <= 1'b0;
            if (frame_start)
                fade_reg <= fade_level;
        end
    end

    assign ram_raddr = {active_bank, pix_pal, pix_index};

    sf_palette_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Stage 1: registered RAM read; remember whether the entry was loaded yet.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p0 <= 1'b0;
            run_p0 <= 1'b0;
        end else begin
            vld_p0 <= pix_valid;
            run_p0 <= init_done;
        end
    end

    // Stage 2: fade each channel; RGB holds while no pixel completes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= vld_p0;
            if (vld_p0) begin
                red   <= run_p0 ? fade_ch(ram_rdata[3*CH_W-1 -: CH_W], fade_reg) : '0;
                green <= run_p0 ? fade_ch(ram_rdata[2*CH_W-1 -: CH_W], fade_reg) : '0;
                blue  <= run_p0 ? fade_ch(ram_rdata[CH_W-1:0], fade_reg) : '0;
            end
        end
    end

endmodule

// File: tb/tb_sf_palette_engine.sv
// Directed bench for sf_palette_engine with an expected-pixel queue checked
// against every out_valid.
module tb_sf_palette_engine;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [4:0]  pix_index;
    logic [1:0]  pix_pal;
    logic [3:0]  red, green, blue;
    logic        out_valid;
    logic        wr_en;
    logic [1:0]  wr_pal;
    logic [4:0]  wr_index;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        swap_req;
    logic        frame_start;
    logic [3:0]  fade_level;
    logic        init_done;

    always #5 Clk = ~Clk;

    sf_palette_engine dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_valid   (pix_valid),
        .pix_index   (pix_index),
        .pix_pal     (pix_pal),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .out_valid   (out_valid),
        .wr_en       (wr_en),
        .wr_pal      (wr_pal),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .swap_req    (swap_req),
        .frame_start (frame_start),
        .fade_level  (fade_level),
        .init_done   (init_done)
    );

    typedef struct {
        logic [11:0] rgb;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
                chk("latency", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("missing_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic push_exp(input logic [11:0] rgb);
        exp_t e;
        e.rgb = rgb;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic pix(input logic [1:0] pal, input logic [4:0] idx, input logic [11:0] rgb);
        pix_valid = 1'b1;
        pix_pal   = pal;
        pix_index = idx;
        push_exp(rgb);
        tick();
        pix_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic wr(input logic [1:0] pal, input logic [4:0] idx, input logic [11:0] data);
        chk("wr_ready", 32'(wr_ready), 32'd1);
        wr_en    = 1'b1;
        wr_pal   = pal;
        wr_index = idx;
        wr_data  = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic frame(input logic [3:0] lvl);
        frame_start = 1'b1;
        fade_level  = lvl;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic req();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Counts cycles from reset release to init_done; optional INIT-time stimulus.
    task automatic wait_init(input string tag, input bit stim);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            pix_valid   = stim && (n == 5);
            pix_pal     = 2'd0;
            pix_index   = 5'd7;
            swap_req    = stim && (n == 10);
            frame_start = stim && (n == 20);
            if (stim && n == 5)
                push_exp(12'h000);
            tick();
            n++;
        end
        pix_valid   = 1'b0;
        swap_req    = 1'b0;
        frame_start = 1'b0;
        chk(tag, 32'(n), 32'd256);
    endtask

    initial begin
        Reset_n     = 1'b0;
        pix_valid   = 1'b0;
        pix_index   = '0;
        pix_pal     = '0;
        wr_en       = 1'b0;
        wr_pal      = '0;
        wr_index    = '0;
        wr_data     = '0;
        swap_req    = 1'b0;
        frame_start = 1'b0;
        fade_level  = 4'hF;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        // INIT with an early pixel, a swap request and an ignored frame_start.
        Reset_n = 1'b1;
        wait_init("init_cycles", 1'b1);
        tick();
        chk("run_wr_ready", 32'(wr_ready), 32'd1);
        pix(2'd2, 5'd7, 12'hFFF);

        // Shadow write invisible until the pending swap from INIT fires.
        wr(2'd1, 5'd0, 12'h0F0);
        pix(2'd1, 5'd0, 12'hA41);
        frame(4'hF);
        pix(2'd1, 5'd0, 12'h0F0);

        // Two requests collapse into one swap back to bank 0.
        req();
        tick();
        req();
        frame(4'hF);
        pix(2'd1, 5'd0, 12'hA41);
        frame(4'hF);
        pix(2'd1, 5'd0, 12'hA41);

        // Fade levels.
        frame(4'd7);
        pix(2'd0, 5'd7, 12'h777);
        pix(2'd0, 5'd0, 12'h520);
        chk("rgb_hold", 32'({red, green, blue}), 32'h520);
        frame(4'd3);
        pix(2'd0, 5'd0, 12'h210);
        frame(4'd0);
        pix(2'd0, 5'd7, 12'h000);
        frame(4'hF);
        pix(2'd0, 5'd7, 12'hFFF);
        pix(2'd0, 5'd36 - 5'd4, 12'hA41);

        // Write, swap_req and swapping frame_start all in one cycle.
        req();
        wr_en       = 1'b1;
        wr_pal      = 2'd0;
        wr_index    = 5'd4;
        wr_data     = 12'hABC;
        swap_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        wr_en       = 1'b0;
        swap_req    = 1'b0;
        frame_start = 1'b0;
        pix(2'd0, 5'd4, 12'hABC);
        frame(4'hF);
        pix(2'd0, 5'd4, 12'h000);
        frame(4'hF);
        pix(2'd0, 5'd4, 12'h000);

        // Move to bank 1, then reset with pixels in flight.
        req();
        frame(4'hF);
        pix(2'd1, 5'd0, 12'h0F0);
        pix(2'd0, 5'd4, 12'hABC);
        pix_valid = 1'b1;
        pix_pal   = 2'd1;
        pix_index = 5'd0;
        push_exp(12'h0F0);
        tick();
        tick();
        pix_valid = 1'b0;
        Reset_n   = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_rgb", 32'({red, green, blue}), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
        sb.delete();
        tick();
        tick();
        Reset_n = 1'b1;
        wait_init("reinit_cycles", 1'b0);
        pix(2'd1, 5'd0, 12'hA41);
        pix(2'd0, 5'd4, 12'h000);
        req();
        frame(4'hF);
        pix(2'd1, 5'd0, 12'hA41);
        pix(2'd0, 5'd4, 12'h000);
        pix(2'd3, 5'd31, 12'hBBC);

        tick();
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
